lab1_selftest_ctrl: RTL and testbench

- Built-in self-test sequencer for the 8-bit switch-to-LED logic block (lab1 datapath).
- Sits between the board switches and the datapath's swt input.
- In normal operation it passes the switch value through unchanged.
- On start it steps through a pattern sweep, waits a settle time per pattern, compares the datapath LEDs against the golden function, and reports error count, first failing pattern and pass/fail.

---
 rtl/lab1_pkg.sv | 24 ++
 rtl/lab1_selftest_cmp.sv | 48 ++++
 rtl/lab1_selftest_ctrl.sv | 109 ++++++++++
 tb/tb_lab1_selftest_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Shared definitions for the lab1 datapath self-test: FSM states, LED width
// and the golden switch-to-LED function used by both the RTL and its bench.
package lab1_pkg;

  localparam int LED_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // bit2 is the OR of the two decoded terms on bits 1 and 3.
  function automatic logic [LED_W-1:0] expected_led(input logic [LED_W-1:0] s);
    logic b1;
    logic b3;
    b1 = s[1] & ~s[2];
    b3 = s[2] & s[3];
    return {s[7:4], b3, b1 | b3, b1, s[0]};
  endfunction

endpackage

// File: rtl/lab1_selftest_cmp.sv
// Registered LED compare: on each check strobe, counts mismatches (saturating
// at 255) and captures the first failing pattern.
module lab1_selftest_cmp
  import lab1_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_check,
  input  logic [LED_W-1:0] i_pattern,
  input  logic [LED_W-1:0] i_led,
  output logic [7:0]       o_err_count,
  output logic             o_fail_valid,
  output logic [LED_W-1:0] o_fail_pat
);

  logic             w_mismatch;
  logic [7:0]       r_err_count;
  logic             r_fail_valid;
  logic [LED_W-1:0] r_fail_pat;

  assign w_mismatch = (i_led != expected_led(i_pattern));

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_pat   <= '0;
    end else if (i_clear) begin
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_pat   <= '0;
    end else if (i_check && w_mismatch) begin
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      if (!r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_pat   <= i_pattern;
      end
    end
  end

  assign o_err_count  = r_err_count;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_pat   = r_fail_pat;

endmodule

// File: rtl/lab1_selftest_ctrl.sv
// Self-test sequencer for the lab1 datapath: passes switches through when idle,
// otherwise sweeps patterns, settles, and compares the LEDs against the golden model.
module lab1_selftest_ctrl
  import lab1_pkg::*;
#(
  parameter int STEP          = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LED_W-1:0] swt_in,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] swt_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic             fail_valid,
  output logic [LED_W-1:0] fail_pat
);

  state_t           r_state;
  state_t           w_next_state;
  logic [LED_W-1:0] r_pattern;
  logic [7:0]       r_settle;
  logic [LED_W-1:0] r_swt_out;
  logic             w_clear;
  logic             w_check;
  logic             w_start_ok;
  logic [LED_W:0]   w_pat_next;

  // The extra carry bit ends the sweep instead of wrapping back to 0.
  assign w_pat_next = {1'b0, r_pattern} + 9'(STEP);
  assign w_start_ok = start && !abort;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_check      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          w_next_state = ST_APPLY;
          w_clear      = 1'b1;
        end
      end
      ST_APPLY:  w_next_state = abort ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                w_next_state = ST_IDLE;
        else if (r_settle == 8'd1) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else begin
          w_check      = 1'b1;
          w_next_state = w_pat_next[LED_W] ? ST_DONE : ST_APPLY;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_settle  <= '0;
      r_swt_out <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          r_swt_out <= swt_in;
          if (w_clear) r_pattern <= '0;
        end
        ST_APPLY: begin
          r_swt_out <= r_pattern;
          r_settle  <= 8'(SETTLE_CYCLES);
        end
        ST_SETTLE: r_settle <= r_settle - 8'd1;
        ST_CHECK:  if (w_check && !w_pat_next[LED_W]) r_pattern <= w_pat_next[LED_W-1:0];
        default: ;
      endcase
    end
  end

  lab1_selftest_cmp u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_check     (w_check),
    .i_pattern   (r_pattern),
    .i_led       (led_in),
    .o_err_count (err_count),
    .o_fail_valid(fail_valid),
    .o_fail_pat  (fail_pat)
  );

  assign swt_out = r_swt_out;
  assign busy    = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done    = (r_state == ST_DONE);
  assign pass    = done && (err_count == 8'd0);

endmodule

// File: tb/tb_lab1_selftest_ctrl.sv
// Bench for lab1_selftest_ctrl: a default instance and a STEP=1 instance, each
// driving a behavioural datapath with selectable faults; results go through a scoreboard.
module tb_lab1_selftest_ctrl;
  import lab1_pkg::*;

  localparam int SETTLE = 4;

  typedef struct {
    logic [7:0] err;
    logic       fv;
    logic [7:0] fp;
    logic       pass;
    int         cycles;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] swt_in;
  logic [7:0] swt_out_a, led_a, err_a, fp_a;
  logic [7:0] swt_out_b, led_b, err_b, fp_b;
  logic       busy_a, done_a, pass_a, fv_a;
  logic       busy_b, done_b, pass_b, fv_b;
  int         mode_a = 0;
  int         mode_b = 0;
  logic       sel_b = 1'b0;

  logic [7:0] obs_swt, obs_err, obs_fp;
  logic       obs_busy, obs_done, obs_pass, obs_fv;

  int         checks = 0;
  int         failures = 0;
  result_t    exp_q[$];
  logic [7:0] pt_q[$];

  always #5 clk = ~clk;

  // Datapath model: 0 = healthy, 1 = led[2] stuck at 0, 2 = every bit inverted.
  function automatic logic [7:0] dp_model(input int mode, input logic [7:0] s);
    logic [7:0] e;
    e = expected_led(s);
    if (mode == 1) e[2] = 1'b0;
    else if (mode == 2) e = ~e;
    return e;
  endfunction

  function automatic result_t model_sweep(input int step, input int mode, input int limit);
    result_t r;
    int      n;
    r = '{err: 8'd0, fv: 1'b0, fp: 8'd0, pass: 1'b0, cycles: 0};
    n = 0;
    for (int p = 0; p <= 255 && p < limit; p += step) begin
      n++;
      if (dp_model(mode, 8'(p)) != expected_led(8'(p))) begin
        if (r.err != 8'hFF) r.err++;
        if (!r.fv) begin
          r.fv = 1'b1;
          r.fp = 8'(p);
        end
      end
    end
    r.pass   = (r.err == 8'd0);
    r.cycles = n * (SETTLE + 2);
    return r;
  endfunction

  assign led_a = dp_model(mode_a, swt_out_a);
  assign led_b = dp_model(mode_b, swt_out_b);

  assign obs_swt  = sel_b ? swt_out_b : swt_out_a;
  assign obs_err  = sel_b ? err_b : err_a;
  assign obs_fp   = sel_b ? fp_b : fp_a;
  assign obs_busy = sel_b ? busy_b : busy_a;
  assign obs_done = sel_b ? done_b : done_a;
  assign obs_pass = sel_b ? pass_b : pass_a;
  assign obs_fv   = sel_b ? fv_b : fv_a;

  lab1_selftest_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .swt_in(swt_in), .led_in(led_a), .swt_out(swt_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fv_a), .fail_pat(fp_a)
  );

  lab1_selftest_ctrl #(.STEP(1), .SETTLE_CYCLES(SETTLE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .swt_in(swt_in), .led_in(led_b), .swt_out(swt_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fv_b), .fail_pat(fp_b)
  );

  task automatic test_reset;
    rst_n = 1'b0; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; swt_in = 8'h00;
    #3;
    checks++;
    if ({busy_a, done_a, pass_a, fv_a, err_a, fp_a, swt_out_a} !== '0) begin
      failures++;
      $display("FAIL reset_a: got busy=%b done=%b pass=%b fv=%b err=%0d fp=%h swt=%h, expected all 0",
               busy_a, done_a, pass_a, fv_a, err_a, fp_a, swt_out_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, fv_b, err_b, fp_b, swt_out_b} !== '0) begin
      failures++;
      $display("FAIL reset_b: got busy=%b done=%b err=%0d swt=%h, expected all 0",
               busy_b, done_b, err_b, swt_out_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough(input string tag);
    logic [7:0] vec [4];
    logic [7:0] e;
    vec = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    sel_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      swt_in = vec[i];
      pt_q.push_back(vec[i]);
      @(negedge clk);
      e = pt_q.pop_front();
      checks++;
      if (swt_out_a !== e) begin
        failures++;
        $display("FAIL passthrough_%s: got %h expected %h", tag, swt_out_a, e);
      end
    end
  endtask

  task automatic run_sweep(input bit b, input int step, input int mode, input int repulse_at);
    result_t e;
    int      n;
    sel_b = b;
    if (b) mode_b = mode; else mode_a = mode;
    exp_q.push_back(model_sweep(step, mode, 256));
    @(negedge clk);
    checks++;
    if (obs_busy !== 1'b0) begin
      failures++; $display("FAIL busy_before_start: got %b expected 0", obs_busy);
    end
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    checks++;
    if (obs_busy !== 1'b1) begin
      failures++; $display("FAIL busy_after_start: got %b expected 1", obs_busy);
    end
    checks++;
    if (obs_err !== 8'd0 || obs_fv !== 1'b0 || obs_done !== 1'b0) begin
      failures++;
      $display("FAIL results_cleared: got err=%0d fv=%b done=%b expected 0/0/0", obs_err, obs_fv, obs_done);
    end
    @(negedge clk);
    n = 1;
    checks++;
    if (obs_swt !== 8'h00) begin
      failures++; $display("FAIL first_pattern: got %h expected 00", obs_swt);
    end
    while (obs_done !== 1'b1 && n < 4000) begin
      if (b) start_b = (n == repulse_at); else start_a = (n == repulse_at);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0; start_b = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (n != e.cycles) begin
      failures++; $display("FAIL sweep_cycles: got %0d expected %0d", n, e.cycles);
    end
    checks++;
    if (obs_err !== e.err) begin
      failures++; $display("FAIL err_count: got %0d expected %0d", obs_err, e.err);
    end
    checks++;
    if (obs_fv !== e.fv || obs_fp !== e.fp) begin
      failures++;
      $display("FAIL fail_info: got fv=%b fp=%h expected fv=%b fp=%h", obs_fv, obs_fp, e.fv, e.fp);
    end
    checks++;
    if (obs_pass !== e.pass || obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL pass_busy: got pass=%b busy=%b expected pass=%b busy=0", obs_pass, obs_busy, e.pass);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_done !== 1'b1 || obs_err !== e.err || obs_pass !== e.pass) begin
      failures++;
      $display("FAIL done_hold: got done=%b err=%0d pass=%b expected 1/%0d/%b", obs_done, obs_err, obs_pass, e.err, e.pass);
    end
  endtask

  task automatic test_abort;
    result_t e;
    logic [7:0] p;
    int n;
    sel_b = 1'b0; mode_a = 1; swt_in = 8'h00;
    exp_q.push_back(model_sweep(2, 1, 16'h10));
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (swt_out_a !== 8'h10 && n < 2000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (swt_out_a !== 8'h10) begin
      failures++; $display("FAIL reach_pattern_10: got %h expected 10", swt_out_a);
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    swt_in = 8'hA5;
    pt_q.push_back(8'hA5);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy_a, done_a);
    end
    e = exp_q.pop_front();
    checks++;
    if (err_a !== e.err || fv_a !== e.fv || fp_a !== e.fp) begin
      failures++;
      $display("FAIL abort_retained: got err=%0d fv=%b fp=%h expected err=%0d fv=%b fp=%h",
               err_a, fv_a, fp_a, e.err, e.fv, e.fp);
    end
    @(negedge clk);
    p = pt_q.pop_front();
    checks++;
    if (swt_out_a !== p) begin
      failures++; $display("FAIL abort_passthrough: got %h expected %h", swt_out_a, p);
    end
    swt_in = 8'h00;
    run_sweep(1'b0, 2, 1, -1);
  endtask

  task automatic test_start_abort_together;
    sel_b = 1'b0; mode_a = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++; $display("FAIL busy_mid_sweep: got %b expected 1", busy_a);
    end
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++; $display("FAIL start_abort_idle: got busy=%b done=%b expected 0/0", busy_a, done_a);
    end
  endtask

  task automatic test_async_reset;
    result_t e;
    logic [7:0] p;
    int n;
    sel_b = 1'b0; mode_a = 1; swt_in = 8'h00;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (swt_out_a !== 8'h40 && n < 2000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (swt_out_a !== 8'h40) begin
      failures++; $display("FAIL reach_pattern_40: got %h expected 40", swt_out_a);
    end
    e = model_sweep(2, 1, 16'h40);
    checks++;
    if (err_a !== e.err) begin
      failures++; $display("FAIL err_before_reset: got %0d expected %0d", err_a, e.err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, fv_a, err_a, fp_a, swt_out_a} !== '0) begin
      failures++;
      $display("FAIL async_reset_clear: got busy=%b done=%b pass=%b fv=%b err=%0d fp=%h swt=%h, expected all 0",
               busy_a, done_a, pass_a, fv_a, err_a, fp_a, swt_out_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    swt_in = 8'h3C;
    pt_q.push_back(8'h3C);
    @(negedge clk);
    p = pt_q.pop_front();
    checks++;
    if (swt_out_a !== p || busy_a !== 1'b0) begin
      failures++; $display("FAIL post_reset_passthrough: got swt=%h busy=%b expected %h/0", swt_out_a, busy_a, p);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough("idle");
    run_sweep(1'b0, 2, 0, -1);
    test_passthrough("done");
    run_sweep(1'b0, 2, 1, -1);
    run_sweep(1'b1, 1, 2, -1);
    test_abort();
    run_sweep(1'b0, 2, 0, 100);
    test_start_abort_together();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
